led_status_ctrl: RTL and testbench
==================================

# led_status_ctrl

Status-lamp controller for the 8-to-16-bit unsigned divider board. It divides the board clock into the 500 ms blink clock `CLK_500ms` and tracks the divider's operation state. It drives the 3-bit `LEDLAMP` status vector consumed by the LED blink gate, which ANDs each lamp bit with `CLK_500ms`. It sits between the divider core/button logic and the LED blink stage.

## Interface

Parameters:
- `HALF_CNT`, default 25000000: board-clock cycles per half period of `CLK_500ms` (50 MHz gives 500 ms). Must be ≥ 2.
- `TIMEOUT_TICKS`, default 10: number of half-period ticks allowed in BUSY before an error is flagged. Range 1..255.

Ports:
- `CLK`  input  1  board clock, all logic on its rising edge.
- `RST`  input  1  reset, asynchronous, active-high.
- `START`  input  1  divider start request, synchronous to `CLK`, rising-edge detected.
- `DONE`  input  1  divider result-valid, level, synchronous.
- `DIV_ZERO`  input  1  divisor-was-zero flag, sampled together with `DONE`.
- `ACK`  input  1  user acknowledge (already debounced), rising-edge detected.
- `CLK_500ms`  output  1  blink square wave, registered.
- `LEDLAMP`  output  3  lamp vector, registered: [0] busy, [1] done, [2] error.

## Operation

- Prescaler:
  - Counter `cnt` counts 0..HALF_CNT-1, then wraps to 0.
  - On the wrap cycle, `CLK_500ms` toggles and an internal one-cycle `tick` asserts.
- Edge detection:
  - `start_q` and `ack_q` register `START` and `ACK`.
  - `start_rise = START & ~start_q`; `ack_rise = ACK & ~ack_q`.
  - Holding an input high produces exactly one event.
- FSM states, with `LEDLAMP` encoding:
  - IDLE = 000
  - BUSY = 001
  - DONE_S = 010
  - ERR = 100
- Transitions, listed highest priority first within each state:
  - IDLE: `start_rise` → BUSY. `ack_rise` is ignored.
  - BUSY: `DONE & DIV_ZERO` → ERR. `DONE & ~DIV_ZERO` → DONE_S. Timeout → ERR. `start_rise` is ignored.
  - DONE_S / ERR: `start_rise` → BUSY, even when `ack_rise` occurs on the same cycle. Otherwise `ack_rise` → IDLE.
- `LEDLAMP` is registered from the next-state value, so it updates on the same edge as the state.
- Timeout counter (8 bits):
  - Cleared on every transition into BUSY.
  - Increments on each `tick` while in BUSY.
  - Asserts timeout when `tick` occurs with count == TIMEOUT_TICKS-1.
  - `DONE` on the same cycle as the timeout wins.

## Timing

- Reset values (applied immediately, asynchronously):
  - `cnt` = 0, `CLK_500ms` = 0.
  - State IDLE, `LEDLAMP` = 000.
  - `start_q` = `ack_q` = 0, timeout count = 0.
- Because `start_q` resets to 0, `START` held high through reset release produces one `start_rise` on the first clock.
- Latency:
  - Input event to `LEDLAMP` change: 1 edge. The input is high at edge k and `LEDLAMP` is valid after edge k.
- `CLK_500ms` timing:
  - First rise is on the HALF_CNT-th rising edge after reset release.
  - Period is 2·HALF_CNT cycles with a 50 % duty cycle.
  - It free-runs independent of the FSM and is never reset by state changes.
- Timeout window:
  - The tick phase is not aligned to BUSY entry.
  - ERR is reached between (TIMEOUT_TICKS-1)·HALF_CNT+1 and TIMEOUT_TICKS·HALF_CNT cycles after entering BUSY.
- `DONE` arriving while not in BUSY is ignored.
- Asserting `RST` mid-operation in any state returns to reset values immediately.

## Configuration

- Macro `LED_TIMEOUT_EN`.
- Defined: the timeout counter and BUSY→ERR timeout transition are compiled in.
- Undefined: the counter is absent and BUSY exits only on `DONE`. `TIMEOUT_TICKS` is unused. All other behaviour is identical.

## Test plan

All scenarios use HALF_CNT=4, TIMEOUT_TICKS=3.

- **Reset and prescaler:** assert `RST` then release, all inputs 0 → `LEDLAMP`=000. `CLK_500ms` is 0, rises at edge 4 after release, and toggles every 4 cycles (period 8).
- **Normal completion:** one-cycle `START` pulse → `LEDLAMP`=001 after that edge. `DONE`=1, `DIV_ZERO`=0 → 010. `ACK` pulse → 000. `START` held high for 20 cycles afterwards → exactly one re-entry to 001.
- **Divide by zero:** from BUSY, `DONE`=1, `DIV_ZERO`=1 → `LEDLAMP`=100. `ACK` held high for 10 cycles → 000 once, with no further change.
- **Timeout, macro defined:** `START`, no `DONE` → `LEDLAMP`=100 within 9..12 cycles of entering BUSY.
- **Timeout, macro undefined:** same stimulus → `LEDLAMP` stays 001 for 100 cycles.
- **Simultaneous events:**
  - In DONE_S, `START` and `ACK` rise together → 001.
  - In BUSY, `DONE` on the timeout tick → 010.
- **Reset mid-BUSY:** `RST` pulsed between clock edges → `LEDLAMP`=000 and `CLK_500ms`=0 before the next edge. The prescaler restarts from 0.

Source files
------------

// File: rtl/led_status_ctrl.sv
// Status-lamp controller: 500 ms blink prescaler plus IDLE/BUSY/DONE/ERR lamp FSM.
// Define LED_TIMEOUT_EN to compile in the BUSY timeout counter and BUSY->ERR timeout exit.
module led_status_ctrl #(
  parameter int unsigned HALF_CNT      = 25000000,
  parameter int unsigned TIMEOUT_TICKS = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       DONE,
  input  logic       DIV_ZERO,
  input  logic       ACK,
  output logic       CLK_500ms,
  output logic [2:0] LEDLAMP
);

  localparam int unsigned   CW      = (HALF_CNT > 1) ? $clog2(HALF_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(HALF_CNT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    DONE_S = 2'd2,
    ERR    = 2'd3
  } state_t;

  logic [CW-1:0] r_cnt;
  logic          r_clk_500ms;
  logic          r_start_q;
  logic          r_ack_q;
  state_t        r_state;
  state_t        w_state_next;
  logic [2:0]    r_lamp;
  logic [2:0]    w_lamp_next;
  logic          w_tick;
  logic          w_start_rise;
  logic          w_ack_rise;
  logic          w_timeout;

  // Empty marker scope: an out-of-range configuration is visible by name in the elaborated hierarchy.
  generate
    if (HALF_CNT < 2 || TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 255) begin : g_bad_params
    end
  endgenerate

  assign w_tick = (r_cnt == CNT_MAX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt       <= '0;
      r_clk_500ms <= 1'b0;
    end else if (w_tick) begin
      r_cnt       <= '0;
      r_clk_500ms <= ~r_clk_500ms;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_start_q <= 1'b0;
      r_ack_q   <= 1'b0;
    end else begin
      r_start_q <= START;
      r_ack_q   <= ACK;
    end
  end

  assign w_start_rise = START & ~r_start_q;
  assign w_ack_rise   = ACK & ~r_ack_q;

`ifdef LED_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_TICKS - 1);

  logic [7:0] r_to_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_to_cnt <= '0;
    end else if (w_state_next == BUSY && r_state != BUSY) begin
      r_to_cnt <= '0;
    end else if (r_state == BUSY && w_tick) begin
      r_to_cnt <= r_to_cnt + 8'd1;
    end
  end

  assign w_timeout = (r_state == BUSY) && w_tick && (r_to_cnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // State register; the lamp register follows the next-state value on the same edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_lamp  <= 3'b000;
    end else begin
      r_state <= w_state_next;
      r_lamp  <= w_lamp_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_start_rise) w_state_next = BUSY;
      end
      BUSY: begin
        if (DONE)           w_state_next = DIV_ZERO ? ERR : DONE_S;
        else if (w_timeout) w_state_next = ERR;
      end
      DONE_S, ERR: begin
        if (w_start_rise)    w_state_next = BUSY;
        else if (w_ack_rise) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_lamp_next = 3'b000;
    case (w_state_next)
      BUSY:    w_lamp_next = 3'b001;
      DONE_S:  w_lamp_next = 3'b010;
      ERR:     w_lamp_next = 3'b100;
      default: w_lamp_next = 3'b000;
    endcase
  end

  assign CLK_500ms = r_clk_500ms;
  assign LEDLAMP   = r_lamp;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl with HALF_CNT=4, TIMEOUT_TICKS=3.
module tb_led_status_ctrl;

  localparam int HC = 4;
  localparam int TT = 3;

  logic       CLK      = 1'b0;
  logic       RST      = 1'b1;
  logic       START    = 1'b0;
  logic       DONE     = 1'b0;
  logic       DIV_ZERO = 1'b0;
  logic       ACK      = 1'b0;
  logic       CLK_500ms;
  logic [2:0] LEDLAMP;

  int errors  = 0;
  int checks  = 0;
  int n_edges = 0;

  led_status_ctrl #(
    .HALF_CNT      (HC),
    .TIMEOUT_TICKS (TT)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .DONE      (DONE),
    .DIV_ZERO  (DIV_ZERO),
    .ACK       (ACK),
    .CLK_500ms (CLK_500ms),
    .LEDLAMP   (LEDLAMP)
  );

  always #5 CLK = ~CLK;

  // Rising edges since reset release: the prescaler phase follows directly from it.
  always @(posedge CLK or posedge RST) begin
    if (RST) n_edges = 0;
    else     n_edges = n_edges + 1;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic exp_clk;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (LEDLAMP !== 3'b000) begin errors++; $display("FAIL reset_lamp: got %b expected 000", LEDLAMP); end
    checks++; if (CLK_500ms !== 1'b0) begin errors++; $display("FAIL reset_clk: got %b expected 0", CLK_500ms); end
    RST = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      exp_clk = (((n_edges / HC) % 2) != 0);
      checks++; if (CLK_500ms !== exp_clk) begin errors++; $display("FAIL prescaler_edge%0d: got %b expected %b", i, CLK_500ms, exp_clk); end
    end
    checks++; if (LEDLAMP !== 3'b000) begin errors++; $display("FAIL reset_idle_lamp: got %b expected 000", LEDLAMP); end
    $display("test_reset: done at edge %0d", n_edges);
  endtask

  task automatic test_normal();
    int entries;
    logic [2:0] prev;
    START = 1'b1; step(); START = 1'b0;
    checks++; if (LEDLAMP !== 3'b001) begin errors++; $display("FAIL norm_busy: got %b expected 001", LEDLAMP); end
    DONE = 1'b1; step(); DONE = 1'b0;
    checks++; if (LEDLAMP !== 3'b010) begin errors++; $display("FAIL norm_done: got %b expected 010", LEDLAMP); end
    ACK = 1'b1; step(); ACK = 1'b0;
    checks++; if (LEDLAMP !== 3'b000) begin errors++; $display("FAIL norm_ack: got %b expected 000", LEDLAMP); end
    step();
    entries = 0;
    prev    = LEDLAMP;
    START   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      DONE = (i == 3);
      step();
      if (LEDLAMP == 3'b001 && prev != 3'b001) entries++;
      prev = LEDLAMP;
    end
    START = 1'b0; DONE = 1'b0;
    checks++; if (entries !== 1) begin errors++; $display("FAIL norm_held_start_entries: got %0d expected 1", entries); end
    checks++; if (LEDLAMP !== 3'b010) begin errors++; $display("FAIL norm_held_start_state: got %b expected 010", LEDLAMP); end
    ACK = 1'b1; step(); ACK = 1'b0;
    checks++; if (LEDLAMP !== 3'b000) begin errors++; $display("FAIL norm_final_ack: got %b expected 000", LEDLAMP); end
    $display("test_normal: done at edge %0d", n_edges);
  endtask

  task automatic test_div_zero();
    int changes;
    logic [2:0] prev;
    START = 1'b1; step(); START = 1'b0;
    checks++; if (LEDLAMP !== 3'b001) begin errors++; $display("FAIL dz_busy: got %b expected 001", LEDLAMP); end
    DONE = 1'b1; DIV_ZERO = 1'b1; step(); DONE = 1'b0; DIV_ZERO = 1'b0;
    checks++; if (LEDLAMP !== 3'b100) begin errors++; $display("FAIL dz_err: got %b expected 100", LEDLAMP); end
    DONE = 1'b1; step(); DONE = 1'b0;
    checks++; if (LEDLAMP !== 3'b100) begin errors++; $display("FAIL dz_done_in_err: got %b expected 100", LEDLAMP); end
    changes = 0;
    prev    = LEDLAMP;
    ACK     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (LEDLAMP != prev) changes++;
      prev = LEDLAMP;
    end
    ACK = 1'b0;
    checks++; if (changes !== 1) begin errors++; $display("FAIL dz_ack_held_changes: got %0d expected 1", changes); end
    checks++; if (LEDLAMP !== 3'b000) begin errors++; $display("FAIL dz_ack_held_state: got %b expected 000", LEDLAMP); end
    DONE = 1'b1; step(); DONE = 1'b0;
    checks++; if (LEDLAMP !== 3'b000) begin errors++; $display("FAIL dz_done_in_idle: got %b expected 000", LEDLAMP); end
    $display("test_div_zero: done at edge %0d", n_edges);
  endtask

  task automatic test_timeout();
    int e;
    int t3;
    int bad;
    START = 1'b1; step(); START = 1'b0;
    e  = n_edges;
    t3 = (e / HC + 1) * HC + (TT - 1) * HC;
    checks++; if (LEDLAMP !== 3'b001) begin errors++; $display("FAIL to_busy: got %b expected 001", LEDLAMP); end
    while (n_edges < t3 - 1) step();
    checks++; if (LEDLAMP !== 3'b001) begin errors++; $display("FAIL to_before_tick: got %b expected 001 (edge %0d)", LEDLAMP, n_edges); end
    step();
`ifdef LED_TIMEOUT_EN
    checks++; if (LEDLAMP !== 3'b100) begin errors++; $display("FAIL to_expire: got %b expected 100 after %0d cycles", LEDLAMP, n_edges - e); end
`else
    checks++; if (LEDLAMP !== 3'b001) begin errors++; $display("FAIL to_disabled_tick: got %b expected 001", LEDLAMP); end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (LEDLAMP !== 3'b001) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL to_disabled_hold: %0d cycles left 001, expected 0", bad); end
`endif
    DONE = 1'b1; step(); DONE = 1'b0;
    ACK  = 1'b1; step(); ACK  = 1'b0;
    checks++; if (LEDLAMP !== 3'b000) begin errors++; $display("FAIL to_recover: got %b expected 000", LEDLAMP); end
    $display("test_timeout: busy entered at edge %0d, third tick at edge %0d", e, t3);
  endtask

  task automatic test_simultaneous();
    int e;
    int t3;
    START = 1'b1; step(); START = 1'b0;
    DONE  = 1'b1; step(); DONE  = 1'b0;
    checks++; if (LEDLAMP !== 3'b010) begin errors++; $display("FAIL sim_setup_done: got %b expected 010", LEDLAMP); end
    START = 1'b1; ACK = 1'b1; step(); START = 1'b0; ACK = 1'b0;
    checks++; if (LEDLAMP !== 3'b001) begin errors++; $display("FAIL sim_start_ack: got %b expected 001", LEDLAMP); end
    e  = n_edges;
    t3 = (e / HC + 1) * HC + (TT - 1) * HC;
    while (n_edges < t3 - 1) step();
    DONE = 1'b1; step(); DONE = 1'b0;
    checks++; if (LEDLAMP !== 3'b010) begin errors++; $display("FAIL sim_done_on_timeout: got %b expected 010 (edge %0d)", LEDLAMP, n_edges); end
    ACK = 1'b1; step(); ACK = 1'b0;
    checks++; if (LEDLAMP !== 3'b000) begin errors++; $display("FAIL sim_ack: got %b expected 000", LEDLAMP); end
    $display("test_simultaneous: done at edge %0d", n_edges);
  endtask

  task automatic test_reset_mid_busy();
    logic exp_clk;
    int guard;
    START = 1'b1; step(); START = 1'b0;
    checks++; if (LEDLAMP !== 3'b001) begin errors++; $display("FAIL rmb_busy: got %b expected 001", LEDLAMP); end
    guard = 0;
    while (((n_edges / HC) % 2) != 1 && guard < 2 * HC) begin
      step();
      guard++;
    end
    checks++; if (CLK_500ms !== 1'b1) begin errors++; $display("FAIL rmb_clk_high: got %b expected 1", CLK_500ms); end
    #2;
    RST   = 1'b1;
    START = 1'b1;
    #1;
    checks++; if (LEDLAMP !== 3'b000) begin errors++; $display("FAIL rmb_async_lamp: got %b expected 000", LEDLAMP); end
    checks++; if (CLK_500ms !== 1'b0) begin errors++; $display("FAIL rmb_async_clk: got %b expected 0", CLK_500ms); end
    step();
    RST = 1'b0;
    step();
    START = 1'b0;
    checks++; if (LEDLAMP !== 3'b001) begin errors++; $display("FAIL rmb_start_through_reset: got %b expected 001", LEDLAMP); end
    for (int i = 2; i <= 5; i++) begin
      step();
      exp_clk = (((n_edges / HC) % 2) != 0);
      checks++; if (CLK_500ms !== exp_clk) begin errors++; $display("FAIL rmb_prescaler_edge%0d: got %b expected %b", i, CLK_500ms, exp_clk); end
    end
    DONE = 1'b1; step(); DONE = 1'b0;
    ACK  = 1'b1; step(); ACK  = 1'b0;
    checks++; if (LEDLAMP !== 3'b000) begin errors++; $display("FAIL rmb_recover: got %b expected 000", LEDLAMP); end
    $display("test_reset_mid_busy: done at edge %0d", n_edges);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_div_zero();
    test_timeout();
    test_simultaneous();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
